serial_addsub: RTL and testbench

// - Parametrised bit-serial adder/subtractor for the DE10-Lite lab designs: WIDTH-bit

---
 rtl/serial_addsub.sv | 185 ++++++++++++++++++
 tb/tb_serial_addsub.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus carry flop, stepped by a
// synchronised pushbutton or by an internal prescaler tick in auto mode.
module serial_addsub #(
  parameter int WIDTH    = 5,
  parameter int AUTO_DIV = 25_000_000
) (
  input  logic                         MAX10_CLK1_50,
  input  logic                         reset_n,
  input  logic                         step_n,
  input  logic                         mode_auto,
  input  logic                         sub,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic [WIDTH-1:0]             sum,
  output logic                         cout,
  output logic                         ovf,
  output logic [$clog2(WIDTH+1)-1:0]   bit_idx,
  output logic [WIDTH-1:0]             bit_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam int PRE_W = $clog2(AUTO_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Step sources ----------------------------------------------------------
  logic             r_step_s1, r_step_s2, r_step_s3;
  logic [PRE_W-1:0] r_presc;
  logic             w_key_step;
  logic             w_tick;
  logic             w_step;

  // Released button reads as 1, so the chain resets high to avoid a phantom press.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_step_s1 <= 1'b1;
      r_step_s2 <= 1'b1;
      r_step_s3 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns this into a real three-stage shift chain.
      r_step_s1 <= step_n;
      r_step_s2 <= r_step_s1;
      r_step_s3 <= r_step_s2;
    end
  end

  assign w_key_step = r_step_s3 & ~r_step_s2;

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (clear || !mode_auto || (r_presc == PRE_LAST)) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = mode_auto & (r_presc == PRE_LAST);
  assign w_step = mode_auto ? w_tick : w_key_step;

  // Sequencer and datapath ------------------------------------------------
  state_t           r_state, w_state_d;
  logic [WIDTH-1:0] r_op_a, r_op_b, w_op_a_d, w_op_b_d;
  logic             r_carry, w_carry_d;
  logic [WIDTH-1:0] r_sum, w_sum_d;
  logic             r_cout, w_cout_d;
  logic             r_ovf, w_ovf_d;
  logic [IDX_W-1:0] r_bit_idx, w_bit_idx_d;
  logic [WIDTH-1:0] r_bit_valid, w_bit_valid_d;
  logic             w_a_bit, w_b_bit, w_s, w_c_out;

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_bit_idx   <= '0;
      r_bit_valid <= '0;
    end else begin
      r_state     <= w_state_d;
      r_op_a      <= w_op_a_d;
      r_op_b      <= w_op_b_d;
      r_carry     <= w_carry_d;
      r_sum       <= w_sum_d;
      r_cout      <= w_cout_d;
      r_ovf       <= w_ovf_d;
      r_bit_idx   <= w_bit_idx_d;
      r_bit_valid <= w_bit_valid_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the case/if tree leaves a signal unassigned and infers a latch.
    w_state_d     = r_state;
    w_op_a_d      = r_op_a;
    w_op_b_d      = r_op_b;
    w_carry_d     = r_carry;
    w_sum_d       = r_sum;
    w_cout_d      = r_cout;
    w_ovf_d       = r_ovf;
    w_bit_idx_d   = r_bit_idx;
    w_bit_valid_d = r_bit_valid;
    w_a_bit       = 1'b0;
    w_b_bit       = 1'b0;

    for (int i = 0; i < WIDTH; i++) begin
      if (r_bit_idx == IDX_W'(i)) begin
        w_a_bit = r_op_a[i];
        w_b_bit = r_op_b[i];
      end
    end
    w_s     = w_a_bit ^ w_b_bit ^ r_carry;
    w_c_out = (w_a_bit & w_b_bit) | (w_a_bit & r_carry) | (w_b_bit & r_carry);

    if (clear) begin
      w_state_d     = S_IDLE;
      w_op_a_d      = '0;
      w_op_b_d      = '0;
      w_carry_d     = 1'b0;
      w_sum_d       = '0;
      w_cout_d      = 1'b0;
      w_ovf_d       = 1'b0;
      w_bit_idx_d   = '0;
      w_bit_valid_d = '0;
    end else if (w_step) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
          w_op_a_d      = a;
          w_op_b_d      = sub ? ~b : b;
          w_carry_d     = sub;
          w_sum_d       = '0;
          w_cout_d      = 1'b0;
          w_ovf_d       = 1'b0;
          w_bit_idx_d   = '0;
          w_bit_valid_d = '0;
          w_state_d     = S_RUN;
        end
        S_RUN: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (r_bit_idx == IDX_W'(i)) begin
              w_sum_d[i]       = w_s;
              w_bit_valid_d[i] = 1'b1;
            end
          end
          w_carry_d   = w_c_out;
          w_bit_idx_d = r_bit_idx + 1'b1;
          if (r_bit_idx == IDX_LAST) begin
            w_cout_d    = w_c_out;
            w_ovf_d     = r_carry ^ w_c_out;
            w_bit_idx_d = IDX_END;
            w_state_d   = S_DONE;
          end
        end
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign bit_idx   = r_bit_idx;
  assign bit_valid = r_bit_valid;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases plus random operands
// compared against an integer-arithmetic reference model.
module tb_serial_addsub;

  localparam int W   = 5;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         reset_n, step_n, mode_auto, sub, clear;
  logic [W-1:0] a, b, sum, bit_valid;
  logic         cout, ovf, busy, done;
  logic [2:0]   bit_idx;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W), .AUTO_DIV(DIV)) dut (
    .MAX10_CLK1_50 (clk),
    .reset_n       (reset_n),
    .step_n        (step_n),
    .mode_auto     (mode_auto),
    .sub           (sub),
    .clear         (clear),
    .a             (a),
    .b             (b),
    .sum           (sum),
    .cout          (cout),
    .ovf           (ovf),
    .bit_idx       (bit_idx),
    .bit_valid     (bit_valid),
    .busy          (busy),
    .done          (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  task automatic model(input int ma, input int mb, input bit ms,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    int sa, sb, r, u;
    sa = (ma >= (1 << (W - 1))) ? ma - (1 << W) : ma;
    sb = (mb >= (1 << (W - 1))) ? mb - (1 << W) : mb;
    if (ms) begin
      u  = ma - mb;
      ec = (ma >= mb);
      r  = sa - sb;
    end else begin
      u  = ma + mb;
      ec = (u >= (1 << W));
      r  = sa + sb;
    end
    es = W'(u & ((1 << W) - 1));
    eo = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endtask

  task automatic press(input int hold);
    @(negedge clk) step_n = 1'b0;
    repeat (hold) @(negedge clk);
    step_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic key_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                        input int nbits);
    a = ta; b = tbv; sub = ts;
    press(3);
    for (int i = 0; i < nbits; i++) press(3);
  endtask

  logic [W-1:0] ra, rb, es;
  logic         rs, ec, eo;

  initial begin
    reset_n = 1'b0; step_n = 1'b1; mode_auto = 1'b0; sub = 1'b0; clear = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_sum", sum, 0);
    check("reset_flags", {cout, ovf, busy, done}, 0);
    check("reset_idx_valid", {bit_idx, bit_valid}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_step", {busy, done}, 0);

    // 22 + 13 with operands scrambled after load
    key_op(5'b10110, 5'b01101, 1'b0, 0);
    check("load_busy", {busy, bit_idx, bit_valid}, {1'b1, 3'd0, 5'd0});
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    repeat (4) press(3);
    check("four_bits_not_done", {done, busy, bit_idx}, {1'b0, 1'b1, 3'd4});
    press(3);
    check("add_sum", sum, 5'b00011);
    check("add_cout_ovf", {cout, ovf}, 2'b10);
    check("add_done", {done, busy, bit_idx, bit_valid}, {1'b1, 1'b0, 3'd5, 5'b11111});

    key_op(5'b00011, 5'b00101, 1'b1, 5);
    check("sub_borrow", {sum, cout, ovf}, {5'b11110, 1'b0, 1'b0});
    key_op(5'b01111, 5'b00001, 1'b0, 5);
    check("add_overflow", {sum, cout, ovf}, {5'b10000, 1'b0, 1'b1});

    // Partial result, then long press counts once
    key_op(5'b10110, 5'b01101, 1'b0, 2);
    check("partial", {bit_valid, sum[1:0], bit_idx, busy}, {5'b00011, 2'b11, 3'd2, 1'b1});
    press(100);
    check("long_press_one_step", {bit_idx, bit_valid}, {3'd3, 5'b00111});

    // Async reset mid-run
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("async_reset", {sum, cout, ovf, bit_idx, bit_valid, busy, done}, 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);

    // Clear coincident with a key step
    key_op(5'b10110, 5'b01101, 1'b0, 2);
    @(negedge clk) step_n = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    check("clear_wins", {sum, cout, ovf, bit_idx, bit_valid, busy, done}, 0);
    step_n = 1'b1;
    repeat (4) @(negedge clk);
    check("clear_stays_idle", {busy, done}, 0);

    // Random operands in key mode
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      key_op(ra, rb, rs, 5);
      model(int'(ra), int'(rb), rs, es, ec, eo);
      check($sformatf("rand%0d_result", i), {sum, cout, ovf}, {es, ec, eo});
      check($sformatf("rand%0d_done", i), {done, bit_valid}, {1'b1, 5'b11111});
    end

    // Auto mode: tick every DIV cycles, load + W bits
    ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
    @(negedge clk) begin a = ra; b = rb; sub = rs; mode_auto = 1'b1; end
    repeat (8) @(negedge clk);
    check("auto_first_bit", {busy, bit_idx}, {1'b1, 3'd1});
    repeat (15) @(negedge clk);
    check("auto_not_yet_done", {done, bit_idx}, {1'b0, 3'd4});
    @(negedge clk);
    mode_auto = 1'b0;
    model(int'(ra), int'(rb), rs, es, ec, eo);
    check("auto_done", {done, sum, cout, ovf}, {1'b1, es, ec, eo});

    // Switch from auto to key mid-run
    ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
    a = ra; b = rb; sub = rs; mode_auto = 1'b1;
    repeat (13) @(negedge clk);
    mode_auto = 1'b0;
    check("toggle_mid_run", {busy, bit_idx}, {1'b1, 3'd2});
    repeat (3) press(3);
    model(int'(ra), int'(rb), rs, es, ec, eo);
    check("toggle_result", {done, bit_valid, sum, cout, ovf}, {1'b1, 5'b11111, es, ec, eo});

    // Prescaler restarts from zero on re-enable
    mode_auto = 1'b1;
    repeat (3) @(negedge clk);
    check("presc_restart_wait", {done, busy}, 2'b10);
    @(negedge clk);
    mode_auto = 1'b0;
    check("presc_restart_tick", {done, busy}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
